// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared types and constants for the instruction-memory responder.
//   imem_state_e : responder FSM states
//   NOP_INSTR    : default instruction returned on an error response
//   WAIT_CNT_W   : width of the wait-state counter (WAIT_STATES range 0..15)
//   addr_is_err  : misaligned / out-of-range fetch address check
package imem_responder_pkg;

  typedef enum logic [1:0] {
    IMEM_IDLE,
    IMEM_WAIT,
    IMEM_RESP
  } imem_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned WAIT_CNT_W = 4;

  // The word index is compared at full width so addresses far beyond the array are
  // flagged rather than aliased onto a low word.
  function automatic logic addr_is_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch bus between the core (master) and the instruction memory (slave).
//   req_valid/req_ready/req_addr : fetch request handshake, byte address
//   flush                        : squash any in-flight fetch
//   rsp_valid/rsp_ready          : response handshake
//   rsp_instr/rsp_addr/rsp_err   : response payload
interface imem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;

  modport master (
    output req_valid,
    output req_addr,
    output flush,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_instr,
    input  rsp_addr,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  flush,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_instr,
    output rsp_addr,
    output rsp_err
  );

endinterface

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 instruction storage, synchronous write, asynchronous read, no reset.
//   i_clk            : clock
//   i_we/i_waddr/i_wdata : write port (out-of-range index ignored)
//   i_raddr/o_rdata  : combinational read port (out-of-range index reads 0)
// The storage array r_mem is reachable hierarchically for preload.
module imem_array #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  localparam bit IS_POW2 = (DEPTH == (32'd1 << AW));

  logic [31:0] r_mem [DEPTH];
  logic        w_wr_ok;
  logic        w_rd_ok;

  // A power-of-two depth cannot be addressed out of range, so skip the compare there.
  if (IS_POW2) begin : g_pow2
    assign w_wr_ok = 1'b1;
    assign w_rd_ok = 1'b1;
  end else begin : g_npow2
    assign w_wr_ok = (32'(i_waddr) < DEPTH);
    assign w_rd_ok = (32'(i_raddr) < DEPTH);
  end

  always_ff @(posedge i_clk) begin
    if (i_we && w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = w_rd_ok ? r_mem[i_raddr] : 32'h0;

endmodule

// File: rtl/imem_responder.sv
// imem_responder: memory end of the core's instruction-fetch interface.
//   i_clk, i_rst         : clock, synchronous active-high reset
//   io_bus (slave)       : fetch request/response handshake plus flush
//   i_ld_we/i_ld_addr/i_ld_data : program load port, active in any state and during reset
//   o_stat_fetches/o_stat_flushes/o_stat_errs : event counters, present only when
//                          IMEM_RESPONDER_STATS_EN is defined
// One request is outstanding at a time; the response appears WAIT_STATES+1 cycles after
// the accept cycle and holds until rsp_ready. flush drops an in-flight fetch.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ERR_INSTR   = NOP_INSTR,
  localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  imem_responder_if.slave       io_bus,
  input  logic                  i_ld_we,
  input  logic [AW-1:0]         i_ld_addr,
  input  logic [31:0]           i_ld_data
`ifdef IMEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]           o_stat_fetches,
  output logic [31:0]           o_stat_flushes,
  output logic [31:0]           o_stat_errs
`endif
);

  if (WAIT_STATES > 15) begin : g_bad_wait
    $error("imem_responder: WAIT_STATES must be in 0..15");
  end

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

  imem_state_e           r_state;
  imem_state_e           w_state_d;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [WAIT_CNT_W-1:0] w_cnt_d;
  logic [31:0]           r_req_addr;
  logic [31:0]           r_rsp_instr;
  logic [31:0]           r_rsp_addr;
  logic                  r_rsp_err;

  logic                  w_accept;
  logic                  w_rsp_hs;
  logic                  w_enter_resp;
  logic [31:0]           w_samp_addr;
  logic                  w_samp_err;
  logic [31:0]           w_rd_data;

  assign io_bus.req_ready = (r_state == IMEM_IDLE) && !io_bus.flush && !i_rst;
  assign w_accept         = io_bus.req_valid && io_bus.req_ready;
  assign w_rsp_hs         = (r_state == IMEM_RESP) && io_bus.rsp_ready;

  // With zero wait states the response is sampled on the accept edge itself, so the
  // address comes straight off the bus; otherwise it comes from the captured copy.
  assign w_samp_addr = (r_state == IMEM_IDLE) ? io_bus.req_addr : r_req_addr;
  assign w_samp_err  = addr_is_err(w_samp_addr, DEPTH);

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (i_ld_we),
    .i_waddr (i_ld_addr),
    .i_wdata (i_ld_data),
    .i_raddr (w_samp_addr[AW+1:2]),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_enter_resp = 1'b0;
    unique case (r_state)
      IMEM_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES == 0) begin
            w_state_d    = IMEM_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_d = IMEM_WAIT;
            w_cnt_d   = WAIT_INIT;
          end
        end
      end
      IMEM_WAIT: begin
        if (io_bus.flush) begin
          w_state_d = IMEM_IDLE;
          w_cnt_d   = '0;
        end else if (r_cnt == CNT_ONE) begin
          w_state_d    = IMEM_RESP;
          w_enter_resp = 1'b1;
          w_cnt_d      = '0;
        end else begin
          w_cnt_d = r_cnt - CNT_ONE;
        end
      end
      IMEM_RESP: begin
        // A flush alongside rsp_ready still counts as a consumed response.
        if (io_bus.rsp_ready || io_bus.flush) begin
          w_state_d = IMEM_IDLE;
        end
      end
      default: begin
        w_state_d = IMEM_IDLE;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IMEM_IDLE;
      r_cnt       <= '0;
      r_req_addr  <= 32'h0;
      r_rsp_instr <= ERR_INSTR;
      r_rsp_addr  <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_accept) begin
        r_req_addr <= io_bus.req_addr;
      end
      // Read is combinational, so a load-port write on this same edge is not yet visible.
      if (w_enter_resp) begin
        r_rsp_addr  <= w_samp_addr;
        r_rsp_err   <= w_samp_err;
        r_rsp_instr <= w_samp_err ? ERR_INSTR : w_rd_data;
      end
    end
  end

  assign io_bus.rsp_valid = (r_state == IMEM_RESP);
  assign io_bus.rsp_instr = r_rsp_instr;
  assign io_bus.rsp_addr  = r_rsp_addr;
  assign io_bus.rsp_err   = r_rsp_err;

`ifdef IMEM_RESPONDER_STATS_EN
  logic [31:0] r_stat_fetches;
  logic [31:0] r_stat_flushes;
  logic [31:0] r_stat_errs;
  logic        w_squash;

  // Only a flush that actually drops a fetch counts; a flush riding on a handshake does not.
  assign w_squash = io_bus.flush &&
                    ((r_state == IMEM_WAIT) || ((r_state == IMEM_RESP) && !io_bus.rsp_ready));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_fetches <= 32'h0;
      r_stat_flushes <= 32'h0;
      r_stat_errs    <= 32'h0;
    end else begin
      if (w_rsp_hs) begin
        r_stat_fetches <= r_stat_fetches + 32'd1;
      end
      if (w_squash) begin
        r_stat_flushes <= r_stat_flushes + 32'd1;
      end
      if (w_rsp_hs && r_rsp_err) begin
        r_stat_errs <= r_stat_errs + 32'd1;
      end
    end
  end

  assign o_stat_fetches = r_stat_fetches;
  assign o_stat_flushes = r_stat_flushes;
  assign o_stat_errs    = r_stat_errs;
`else
  logic w_unused;
  assign w_unused = w_rsp_hs;
`endif

endmodule
